// File: rtl/pe_load_scheduler_pkg.sv
// Shared definitions for the PE load scheduler and its read controllers:
// scheduler state encoding and dataflow mode constants.
package pe_load_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CLR    = 4'd1,
    ST_REQ_F  = 4'd2,
    ST_WAIT_F = 4'd3,
    ST_REQ_I  = 4'd4,
    ST_WAIT_I = 4'd5,
    ST_COMP   = 4'd6,
    ST_WAIT_C = 4'd7,
    ST_NEXT   = 4'd8,
    ST_FIN    = 4'd9
  } state_e;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;

  // Mode 2 streams a fresh filter for every output window.
  function automatic logic reload_filter_each_window(input logic [1:0] m);
    return (m == MODE_2);
  endfunction

endpackage

// File: rtl/pe_load_scheduler_counter.sv
// Parameterised up-counter with synchronous clear and a carry-out that flags
// the last count value (max_count - 1).
module pe_load_scheduler_counter
  import pe_load_scheduler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt,
  input  logic [WIDTH-1:0] max_count,
  output logic [WIDTH-1:0] count,
  output logic             co
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign co    = (count_q == (max_count - WIDTH'(1)));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (cnt) begin
      count_d = co ? '0 : (count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_load_scheduler.sv
// Row sequencer for one PE: loads the filter scratchpad once per row (or per
// window in mode 2), reloads the ifmap scratchpad per window, then kicks the MAC.
module pe_load_scheduler
  import pe_load_scheduler_pkg::*;
#(
  parameter int FILTER_SIZE_WIDTH = 3,
  parameter int WIN_CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [WIN_CNT_WIDTH-1:0] num_windows,
  input  logic                     filter_done,
  input  logic                     ifmap_done,
  input  logic                     compute_done,
  output logic                     clr_filter_addr,
  output logic                     clr_ifmap_addr,
  output logic                     r_next_filter,
  output logic                     r_next_ifmap,
  output logic                     compute_start,
  output logic [WIN_CNT_WIDTH-1:0] window_idx,
  output logic                     busy,
  output logic                     done
);

  // Filter size only travels to status logic elsewhere; nothing here uses it.
  if (FILTER_SIZE_WIDTH < 1) begin : g_filter_size_width_invalid
  end

  state_e                   state_q, state_d;
  logic [1:0]               mode_q;
  logic [WIN_CNT_WIDTH-1:0] num_q;
  logic                     armed_q, armed_d;
  logic                     cdone_q, cdone_d;
  logic                     done_q;

  logic clr_filter_c, clr_ifmap_c, r_next_filter_c, r_next_ifmap_c, compute_start_c;
  logic cnt_clr, cnt_inc, last_win;
  logic accept;

  assign accept = (state_q == ST_IDLE) && start && (num_windows != '0);

  pe_load_scheduler_counter #(
    .WIDTH(WIN_CNT_WIDTH)
  ) u_win_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .cnt      (cnt_inc),
    .max_count(num_q),
    .count    (window_idx),
    .co       (last_win)
  );

  // armed_q is low in the first cycle of a wait state, so a read controller
  // that is slow to drop valid_end cannot release the wait early.
  always_comb begin
    state_d         = state_q;
    armed_d         = 1'b0;
    cdone_d         = cdone_q;
    clr_filter_c    = 1'b0;
    clr_ifmap_c     = 1'b0;
    r_next_filter_c = 1'b0;
    r_next_ifmap_c  = 1'b0;
    compute_start_c = 1'b0;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_windows != '0) begin
            state_d = ST_CLR;
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_CLR: begin
        clr_filter_c = 1'b1;
        clr_ifmap_c  = 1'b1;
        state_d      = ST_REQ_F;
      end
      ST_REQ_F: begin
        r_next_filter_c = 1'b1;
        state_d         = ST_WAIT_F;
      end
      ST_WAIT_F: begin
        armed_d = 1'b1;
        if (armed_q && filter_done) begin
          state_d = ST_REQ_I;
        end
      end
      ST_REQ_I: begin
        r_next_ifmap_c = 1'b1;
        state_d        = ST_WAIT_I;
      end
      ST_WAIT_I: begin
        armed_d = 1'b1;
        cdone_d = 1'b0;
        if (armed_q && ifmap_done) begin
          state_d = ST_COMP;
        end
      end
      ST_COMP: begin
        compute_start_c = 1'b1;
        if (compute_done) begin
          cdone_d = 1'b1;
        end
        state_d = ST_WAIT_C;
      end
      ST_WAIT_C: begin
        if (compute_done || cdone_q) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_win) begin
          state_d = ST_FIN;
        end else begin
          cnt_inc     = 1'b1;
          clr_ifmap_c = 1'b1;
          if (reload_filter_each_window(mode_q)) begin
            clr_filter_c = 1'b1;
            state_d      = ST_REQ_F;
          end else begin
            state_d = ST_REQ_I;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // done is registered off FIN so it lands in the cycle busy has already dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_0;
      num_q   <= '0;
      armed_q <= 1'b0;
      cdone_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cdone_q <= cdone_d;
      done_q  <= (state_q == ST_FIN);
      if (accept) begin
        mode_q <= mode;
        num_q  <= num_windows;
      end
    end
  end

  // Pulses are suppressed while rst is held so nothing escapes the reset cycle.
  assign clr_filter_addr = clr_filter_c & ~rst;
  assign clr_ifmap_addr  = clr_ifmap_c & ~rst;
  assign r_next_filter   = r_next_filter_c & ~rst;
  assign r_next_ifmap    = r_next_ifmap_c & ~rst;
  assign compute_start   = compute_start_c & ~rst;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Directed bench for pe_load_scheduler with simple 4-cycle read controller
// models and a 3-cycle (or same-cycle) compute model.
module tb_pe_load_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] num_windows;
  logic         filter_done, ifmap_done, compute_done;
  logic         clr_filter_addr, clr_ifmap_addr, r_next_filter, r_next_ifmap, compute_start;
  logic [W-1:0] window_idx;
  logic         busy, done;

  int tests = 0;
  int fails = 0;

  int n_rf, n_ri, n_cs, n_done, n_clrf, n_clri;
  logic [W-1:0] win_log [8];

  int   f_cnt, i_cnt, c_cnt;
  logic early;

  pe_load_scheduler #(.FILTER_SIZE_WIDTH(3), .WIN_CNT_WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .num_windows    (num_windows),
    .filter_done    (filter_done),
    .ifmap_done     (ifmap_done),
    .compute_done   (compute_done),
    .clr_filter_addr(clr_filter_addr),
    .clr_ifmap_addr (clr_ifmap_addr),
    .r_next_filter  (r_next_filter),
    .r_next_ifmap   (r_next_ifmap),
    .compute_start  (compute_start),
    .window_idx     (window_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Read controllers: valid_end drops after a request and rises 4 cycles later.
  assign filter_done  = (f_cnt == 0);
  assign ifmap_done   = (i_cnt == 0);
  assign compute_done = early ? compute_start : (c_cnt == 1);

  always @(posedge clk) begin
    if (rst) begin
      f_cnt <= 0;
      i_cnt <= 0;
      c_cnt <= 0;
    end else begin
      f_cnt <= r_next_filter ? 4 : ((f_cnt > 0) ? f_cnt - 1 : 0);
      i_cnt <= r_next_ifmap ? 4 : ((i_cnt > 0) ? i_cnt - 1 : 0);
      c_cnt <= compute_start ? 3 : ((c_cnt > 0) ? c_cnt - 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (r_next_filter)   n_rf++;
    if (r_next_ifmap)    n_ri++;
    if (clr_filter_addr) n_clrf++;
    if (clr_ifmap_addr)  n_clri++;
    if (done)            n_done++;
    if (compute_start) begin
      if (n_cs < 8) win_log[n_cs] = window_idx;
      n_cs++;
    end
  end

  task automatic clear_counts();
    n_rf = 0; n_ri = 0; n_cs = 0; n_done = 0; n_clrf = 0; n_clri = 0;
    for (int i = 0; i < 8; i++) win_log[i] = '1;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [W-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; mode = m; num_windows = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 2'd2; num_windows = 8'd5; early = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    tests++; if (window_idx !== 8'd0) begin fails++; $display("[TB] FAIL reset_window_idx: got %0d want 0", window_idx); end
    tests++; if ({clr_filter_addr, clr_ifmap_addr, r_next_filter, r_next_ifmap, compute_start} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_pulses: got %b want 00000",
        {clr_filter_addr, clr_ifmap_addr, r_next_filter, r_next_ifmap, compute_start});
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_row();
    logic seen;
    int   k;
    clear_counts();
    pulse_start(2'd0, 8'd3);
    @(negedge clk);
    tests++; if ({clr_filter_addr, clr_ifmap_addr, r_next_filter} !== 3'b110) begin
      fails++; $display("[TB] FAIL basic_clr_cycle: got %b want 110", {clr_filter_addr, clr_ifmap_addr, r_next_filter});
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy: got %b want 1", busy); end
    @(negedge clk);
    tests++; if (r_next_filter !== 1'b1) begin fails++; $display("[TB] FAIL basic_start_to_rnf: got %b want 1", r_next_filter); end
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (filter_done) break;
    end
    @(negedge clk);
    tests++; if (r_next_ifmap !== 1'b1) begin fails++; $display("[TB] FAIL basic_fdone_to_rni: got %b want 1", r_next_ifmap); end
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ifmap_done) break;
    end
    @(negedge clk);
    tests++; if (compute_start !== 1'b1) begin fails++; $display("[TB] FAIL basic_idone_to_cs: got %b want 1", compute_start); end
    wait_done(seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL basic_done_timeout: got %b want 1", seen); end
    tests++; if (n_rf !== 1) begin fails++; $display("[TB] FAIL basic_rnf_count: got %0d want 1", n_rf); end
    tests++; if (n_ri !== 3) begin fails++; $display("[TB] FAIL basic_rni_count: got %0d want 3", n_ri); end
    tests++; if (n_cs !== 3) begin fails++; $display("[TB] FAIL basic_cs_count: got %0d want 3", n_cs); end
    tests++; if (n_done !== 1) begin fails++; $display("[TB] FAIL basic_done_count: got %0d want 1", n_done); end
    tests++; if (n_clrf !== 1) begin fails++; $display("[TB] FAIL basic_clrf_count: got %0d want 1", n_clrf); end
    tests++; if (n_clri !== 3) begin fails++; $display("[TB] FAIL basic_clri_count: got %0d want 3", n_clri); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (win_log[i] !== W'(i)) begin
        fails++; $display("[TB] FAIL basic_window_seq[%0d]: got %0d want %0d", i, win_log[i], i);
      end
    end
    tests++; if (window_idx !== 8'd2) begin fails++; $display("[TB] FAIL basic_idx_hold: got %0d want 2", window_idx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_mode2();
    logic seen;
    clear_counts();
    pulse_start(2'd2, 8'd2);
    wait_done(seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL mode2_done_timeout: got %b want 1", seen); end
    tests++; if (n_rf !== 2) begin fails++; $display("[TB] FAIL mode2_rnf_count: got %0d want 2", n_rf); end
    tests++; if (n_clrf !== 2) begin fails++; $display("[TB] FAIL mode2_clrf_count: got %0d want 2", n_clrf); end
    tests++; if (n_ri !== 2) begin fails++; $display("[TB] FAIL mode2_rni_count: got %0d want 2", n_ri); end
    tests++; if (n_cs !== 2) begin fails++; $display("[TB] FAIL mode2_cs_count: got %0d want 2", n_cs); end
  endtask

  task automatic test_zero_windows();
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; num_windows = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL zero_done_early: got %b want 0", done); end
    @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL zero_done_at_2: got %b want 1", done); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL zero_done_width: got %b want 0", done); end
    tests++; if (n_rf + n_ri + n_clrf + n_clri !== 0) begin
      fails++; $display("[TB] FAIL zero_no_pulses: got %0d want 0", n_rf + n_ri + n_clrf + n_clri);
    end
  endtask

  task automatic test_early_compute();
    logic seen;
    clear_counts();
    early = 1'b1;
    pulse_start(2'd0, 8'd2);
    wait_done(seen);
    early = 1'b0;
    tests++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL early_done_timeout: got %b want 1", seen); end
    tests++; if (n_cs !== 2) begin fails++; $display("[TB] FAIL early_cs_count: got %0d want 2", n_cs); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int   ri_seen;
    clear_counts();
    ri_seen = 0;
    pulse_start(2'd0, 8'd3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (r_next_ifmap) ri_seen++;
      if (ri_seen == 2) break;
    end
    tests++; if (window_idx !== 8'd1) begin fails++; $display("[TB] FAIL rstmid_reached_w1: got %0d want 1", window_idx); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({r_next_filter, r_next_ifmap, compute_start, clr_ifmap_addr} !== 4'b0) begin
      fails++; $display("[TB] FAIL rstmid_pulses: got %b want 0000", {r_next_filter, r_next_ifmap, compute_start, clr_ifmap_addr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
    tests++; if (window_idx !== 8'd0) begin fails++; $display("[TB] FAIL rstmid_idx: got %0d want 0", window_idx); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_done: got %b want 0", done); end
    clear_counts();
    pulse_start(2'd0, 8'd3);
    wait_done(seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_rerun_timeout: got %b want 1", seen); end
    tests++; if ({n_rf, n_ri, n_cs} !== {32'd1, 32'd3, 32'd3}) begin
      fails++; $display("[TB] FAIL rstmid_rerun_counts: got rf=%0d ri=%0d cs=%0d want 1 3 3", n_rf, n_ri, n_cs);
    end
    tests++; if (win_log[2] !== 8'd2) begin fails++; $display("[TB] FAIL rstmid_rerun_last_idx: got %0d want 2", win_log[2]); end
  endtask

  task automatic test_start_ignored();
    logic seen;
    clear_counts();
    pulse_start(2'd0, 8'd3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (compute_start) break;
    end
    @(posedge clk); #1;
    start = 1'b1; num_windows = 8'd5; mode = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(seen);
    repeat (10) @(posedge clk);
    #1;
    tests++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL ignore_done_timeout: got %b want 1", seen); end
    tests++; if ({n_rf, n_ri, n_cs, n_done} !== {32'd1, 32'd3, 32'd3, 32'd1}) begin
      fails++; $display("[TB] FAIL ignore_counts: got rf=%0d ri=%0d cs=%0d done=%0d want 1 3 3 1", n_rf, n_ri, n_cs, n_done);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_no_restart: got %b want 0", busy); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_basic_row();
    test_mode2();
    test_zero_windows();
    test_early_compute();
    test_reset_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_load_scheduler.md
Name: pe_load_scheduler

Overview:
- Top-level sequencer for one PE's scratchpad fill and compute.
- Commands the filter and ifmap buffer-read controllers to load their scratchpads, then starts PE compute.
- Walks the output windows of one row.
- Loads the filter once per row. Reloads the ifmap scratchpad once per window, then hands off to the MAC datapath.

Parameters:
- FILTER_SIZE_WIDTH, 3, width of filter_size; forwarded unchanged to status only.
- WIN_CNT_WIDTH, 8, width of num_windows and window_idx.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle request to process one output row
- mode  input  2  dataflow mode; sampled at start, held in mode_q
- num_windows  input  WIN_CNT_WIDTH  output windows in the row; sampled at start
- filter_done  input  1  valid_end of the filter read controller (high while that controller is idle)
- ifmap_done  input  1  valid_end of the ifmap read controller
- compute_done  input  1  one-cycle pulse from the PE datapath when a window's MAC finishes
- clr_filter_addr  output  1  clear filter scratchpad write address
- clr_ifmap_addr  output  1  clear ifmap scratchpad write address
- r_next_filter  output  1  one-cycle request to the filter read controller
- r_next_ifmap  output  1  one-cycle request to the ifmap read controller
- compute_start  output  1  one-cycle pulse to the PE datapath
- window_idx  output  WIN_CNT_WIDTH  current window index
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the row completes

Behaviour:
- Reset values: state IDLE; window_idx 0; mode_q 0; num_q 0. All pulse outputs, busy and done are 0.
- Reset mid-operation returns to IDLE on the next edge. No pulses are emitted on the reset cycle or the cycle after.
- States: IDLE, CLR, REQ_F, WAIT_F, REQ_I, WAIT_I, COMP, WAIT_C, NEXT, FIN.
- IDLE:
  - If start and num_windows≠0: latch mode and num_windows, clear window_idx, go to CLR.
  - If start and num_windows=0: go to FIN.
  - start while busy is ignored.
- CLR: assert clr_filter_addr and clr_ifmap_addr for exactly one cycle. Go to REQ_F.
- REQ_F: assert r_next_filter for one cycle. Go to WAIT_F.
- WAIT_F: stay until filter_done=1, then go to REQ_I.
  - The read controller drops valid_end in the cycle after the request, so WAIT_F never sees a stale high.
  - The scheduler still ignores filter_done in the first WAIT_F cycle, to tolerate a controller that is slow to leave its idle state.
- REQ_I / WAIT_I: same protocol as REQ_F / WAIT_F, using r_next_ifmap and ifmap_done.
- COMP: assert compute_start for one cycle. Go to WAIT_C.
- WAIT_C: wait for compute_done. A compute_done pulse arriving in COMP, before the scheduler is in WAIT_C, is captured in a sticky flag and honoured.
- NEXT:
  - If window_idx = num_q−1: go to FIN.
  - Otherwise: window_idx+1, assert clr_ifmap_addr for this one cycle, go to REQ_I. The filter is not reloaded.
  - Exception, mode_q=2: the filter is reloaded every window. Go to REQ_F and also assert clr_filter_addr.
- FIN: done=1 for one cycle, busy=0. Return to IDLE. window_idx holds its final value until the next start.
- Latency, window 0: start → r_next_filter = 2 cycles (IDLE→CLR→REQ_F).
- Latency, filter_done high → r_next_ifmap = 1 cycle. ifmap_done high → compute_start = 1 cycle.
- Arithmetic: window_idx compares against num_q−1 computed in WIN_CNT_WIDTH bits. num_q=0 never reaches NEXT.
- Simultaneous done inputs: filter_done and ifmap_done are only evaluated in their own wait state. Other values are don't-care.
- compute_done outside COMP/WAIT_C is ignored, and the sticky flag is cleared in COMP's predecessor.

Decomposition:
- Shared package holds the state encoding localparams and the mode constants MODE_0..MODE_2, shared with the read controllers.
- Sub-module: the existing parameterised counter, instantiated as the window counter. It uses max_count=num_q, clr from CLR, and cnt from NEXT; its co drives the NEXT→FIN decision.

Test Plan:
- Basic row: num_windows=3, mode=0. Read controllers modelled with a 4-cycle fill. Required sequence:
  - 1 r_next_filter, 3 r_next_ifmap, 3 compute_start, done once.
  - window_idx steps 0,1,2.
- Mode 2: num_windows=2. Required: 2 r_next_filter, with clr_filter_addr pulsed at CLR and at NEXT.
- num_windows=0: start → done exactly 2 cycles later. No r_next or clr pulses.
- Early compute_done: compute_done arrives the same cycle compute_start is asserted. Required: advances to NEXT without hanging.
- Reset during WAIT_I of window 1:
  - busy=0 next cycle, window_idx=0.
  - A subsequent start runs a full row correctly.
- start pulsed during WAIT_C: ignored. Counts are unchanged from the basic row.
